// File: rtl/andla_exram_addr_rf_pkg.sv
// Shared definitions for the exram base-address register file:
// default bus widths, per-entry CSR widths and the register-bus address map.
package andla_exram_addr_rf_pkg;

  // Default register-bus geometry.
  localparam int EXRAM_DATA_W    = 32;
  localparam int EXRAM_ENTRY_NUM = 8;
  localparam int EXRAM_ADDR_W    = 4;

  // Each live base address spans two bus words (MSB word : LSB word).
  localparam int CSR_EXRAM_BASED_ADDR_BITWIDTH   = 2 * EXRAM_DATA_W;
  localparam int CSR_EXRAM_BASED_ADDR_0_BITWIDTH = CSR_EXRAM_BASED_ADDR_BITWIDTH;
  localparam int CSR_EXRAM_BASED_ADDR_1_BITWIDTH = CSR_EXRAM_BASED_ADDR_BITWIDTH;
  localparam int CSR_EXRAM_BASED_ADDR_2_BITWIDTH = CSR_EXRAM_BASED_ADDR_BITWIDTH;
  localparam int CSR_EXRAM_BASED_ADDR_3_BITWIDTH = CSR_EXRAM_BASED_ADDR_BITWIDTH;
  localparam int CSR_EXRAM_BASED_ADDR_4_BITWIDTH = CSR_EXRAM_BASED_ADDR_BITWIDTH;
  localparam int CSR_EXRAM_BASED_ADDR_5_BITWIDTH = CSR_EXRAM_BASED_ADDR_BITWIDTH;
  localparam int CSR_EXRAM_BASED_ADDR_6_BITWIDTH = CSR_EXRAM_BASED_ADDR_BITWIDTH;
  localparam int CSR_EXRAM_BASED_ADDR_7_BITWIDTH = CSR_EXRAM_BASED_ADDR_BITWIDTH;

  // Address map: entry n occupies words STRIDE*n + {LSB_OFS, MSB_OFS}.
  localparam int CSR_EXRAM_BASED_ADDR_STRIDE  = 2;
  localparam int CSR_EXRAM_BASED_ADDR_LSB_OFS = 0;
  localparam int CSR_EXRAM_BASED_ADDR_MSB_OFS = 1;

  // Word address of the LSB half of entry n.
  function automatic int exram_lsb_addr(input int n);
    return n * CSR_EXRAM_BASED_ADDR_STRIDE + CSR_EXRAM_BASED_ADDR_LSB_OFS;
  endfunction

  // Word address of the MSB half of entry n.
  function automatic int exram_msb_addr(input int n);
    return n * CSR_EXRAM_BASED_ADDR_STRIDE + CSR_EXRAM_BASED_ADDR_MSB_OFS;
  endfunction

endpackage

// File: rtl/andla_exram_addr_rf_entry.sv
// One exram base-address entry: LSB shadow, staged 64-bit value, pending
// flag and the live value seen by the consumer.
//
// Update protocol:
//   - An LSB write only lands in the shadow; nothing visible changes.
//   - An MSB write combines {wdata, shadow} into staged. If the consumer is
//     idle (i_busy=0) in that cycle the value goes straight to live on the
//     same edge; otherwise pend is set and live waits.
//   - While pend=1, live is loaded from staged on the first edge at which
//     i_busy is sampled 0. A later MSB write while pending just replaces
//     staged (last write wins) and leaves pend set.
module andla_exram_addr_entry
  import andla_exram_addr_rf_pkg::*;
#(
  parameter int DATA_W = EXRAM_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_lsb_we,
  input  logic                i_msb_we,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic                i_busy,
  output logic [2*DATA_W-1:0] o_live,
  output logic                o_pend
);

  logic [DATA_W-1:0]   r_lsb_shadow;
  logic [2*DATA_W-1:0] r_staged;
  logic [2*DATA_W-1:0] r_live;
  logic                r_pend;
  logic [2*DATA_W-1:0] w_new_value;

  // Value an MSB write would commit: new upper word over the shadowed lower word.
  assign w_new_value = {i_wdata, r_lsb_shadow};

  // LSB shadow capture; independent of pend so staged is never disturbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lsb_shadow <= '0;
    end else if (i_lsb_we) begin
      r_lsb_shadow <= i_wdata;
    end
  end

  // Staged value: every MSB write overwrites it, pending or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_staged <= '0;
    end else if (i_msb_we) begin
      r_staged <= w_new_value;
    end
  end

  // Pend flag and live value: immediate commit when idle, deferred when busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_live <= '0;
    end else if (i_msb_we) begin
      if (i_busy) begin
        r_pend <= 1'b1;
      end else begin
        r_pend <= 1'b0;
        r_live <= w_new_value;
      end
    end else if (r_pend && !i_busy) begin
      r_pend <= 1'b0;
      r_live <= r_staged;
    end
  end

  assign o_live = r_live;
  assign o_pend = r_pend;

endmodule

// File: rtl/andla_exram_addr_rf.sv
// Exram base-address register file. Holds ENTRY_NUM 64-bit base addresses
// written as two 32-bit bus words and applies them to the consumer only
// when it is not mid-job.
//
// Bus handshake: a request is the single-cycle assertion of sfr_req with
// sfr_we/sfr_addr/sfr_wdata valid in that same cycle. There is no ready or
// back-pressure: every request is accepted on the edge where it is sampled
// and acknowledged by sfr_ack=1 during the following cycle, so requests may
// be issued on every cycle and are acknowledged in order. sfr_rdata carries
// the read word while sfr_ack=1 for a read and is 0 at all other times.
// Reads always return the live values, never shadow or staged data.
//
// The output port list is fixed at eight entries; ENTRY_NUM is expected to
// stay at its default of 8.
module andla_exram_addr_rf
  import andla_exram_addr_rf_pkg::*;
#(
  parameter int DATA_W    = EXRAM_DATA_W,
  parameter int ENTRY_NUM = EXRAM_ENTRY_NUM,
  parameter int ADDR_W    = EXRAM_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sfr_req,
  input  logic                sfr_we,
  input  logic [ADDR_W-1:0]   sfr_addr,
  input  logic [DATA_W-1:0]   sfr_wdata,
  output logic                sfr_ack,
  output logic [DATA_W-1:0]   sfr_rdata,
  input  logic                csr_busy,
  output logic                pend_any,
  output logic [2*DATA_W-1:0] rf_csr_exram_based_addr_0,
  output logic [2*DATA_W-1:0] rf_csr_exram_based_addr_1,
  output logic [2*DATA_W-1:0] rf_csr_exram_based_addr_2,
  output logic [2*DATA_W-1:0] rf_csr_exram_based_addr_3,
  output logic [2*DATA_W-1:0] rf_csr_exram_based_addr_4,
  output logic [2*DATA_W-1:0] rf_csr_exram_based_addr_5,
  output logic [2*DATA_W-1:0] rf_csr_exram_based_addr_6,
  output logic [2*DATA_W-1:0] rf_csr_exram_based_addr_7
);

  logic                r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_wr;
  logic [ENTRY_NUM-1:0] w_lsb_we;
  logic [ENTRY_NUM-1:0] w_msb_we;
  logic [ENTRY_NUM-1:0] w_pend;
  logic [2*DATA_W-1:0] w_live [ENTRY_NUM];

  assign w_wr = sfr_req && sfr_we;

  // Per-entry write decode and entry storage.
  for (genvar n = 0; n < ENTRY_NUM; n++) begin : g_entry
    assign w_lsb_we[n] = w_wr && (sfr_addr == ADDR_W'(exram_lsb_addr(n)));
    assign w_msb_we[n] = w_wr && (sfr_addr == ADDR_W'(exram_msb_addr(n)));

    andla_exram_addr_entry #(
      .DATA_W (DATA_W)
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .i_lsb_we (w_lsb_we[n]),
      .i_msb_we (w_msb_we[n]),
      .i_wdata  (sfr_wdata),
      .i_busy   (csr_busy),
      .o_live   (w_live[n]),
      .o_pend   (w_pend[n])
    );
  end

  // Read mux: select the addressed half of the live value (pre-edge state).
  always_comb begin
    w_rd_data = '0;
    for (int n = 0; n < ENTRY_NUM; n++) begin
      if (sfr_addr == ADDR_W'(exram_lsb_addr(n))) begin
        w_rd_data = w_live[n][DATA_W-1:0];
      end
      if (sfr_addr == ADDR_W'(exram_msb_addr(n))) begin
        w_rd_data = w_live[n][2*DATA_W-1:DATA_W];
      end
    end
  end

  // Acknowledge and read-data register: one cycle after each request,
  // data only for reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= sfr_req;
      r_rdata <= (sfr_req && !sfr_we) ? w_rd_data : '0;
    end
  end

  assign sfr_ack   = r_ack;
  assign sfr_rdata = r_rdata;
  assign pend_any  = |w_pend;

  assign rf_csr_exram_based_addr_0 = w_live[0];
  assign rf_csr_exram_based_addr_1 = w_live[1];
  assign rf_csr_exram_based_addr_2 = w_live[2];
  assign rf_csr_exram_based_addr_3 = w_live[3];
  assign rf_csr_exram_based_addr_4 = w_live[4];
  assign rf_csr_exram_based_addr_5 = w_live[5];
  assign rf_csr_exram_based_addr_6 = w_live[6];
  assign rf_csr_exram_based_addr_7 = w_live[7];

endmodule
